// File: rtl/sap_pkg.sv
// -----------------------------------------------------------------------------
// sap_pkg
// Shared types for the parametrised SAP accumulator core.
//   OPC_W    : opcode field width (top bits of every instruction word)
//   opcode_e : instruction opcodes; values 8..D are unassigned and act as NOP
//   state_e  : control FSM states, also exported on state_dbg
// -----------------------------------------------------------------------------
package sap_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_STA = 4'h3,
        OP_LDI = 4'h4,
        OP_JMP = 4'h5,
        OP_JC  = 4'h6,
        OP_JZ  = 4'h7,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_HALT  = 3'd3,
        ST_LOAD  = 3'd4
    } state_e;

endpackage

// File: rtl/sap_ram.sv
// -----------------------------------------------------------------------------
// sap_ram
// Program/data memory: 2**ADDR_W words of DATA_W bits, asynchronous read,
// synchronous write. Contents are not reset.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module sap_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/sap_core_param.sv
// -----------------------------------------------------------------------------
// sap_core_param
// Parametrised SAP-1 style accumulator CPU: two clocks per instruction
// (FETCH, EXEC), free-run or single-step control, host program-load mode.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : 1 = free-run, 0 = one instruction per step rising edge
//   step        : step request level (edge detected internally)
//   load_en     : request program-load mode
//   load_we     : RAM write strobe while in LOAD
//   load_addr   : RAM write address while in LOAD
//   load_data   : RAM write data while in LOAD
//   out_data    : value of A at the last OUT instruction
//   out_valid   : one-cycle pulse following each OUT
//   halted      : high while in HALT
//   pc_dbg      : program counter
//   state_dbg   : FSM state encoding (state_e)
// -----------------------------------------------------------------------------
module sap_core_param
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              step,
    input  logic              load_en,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [2:0]        state_dbg
);

    if (ADDR_W < 1 || ADDR_W > DATA_W - OPC_W) begin : g_param_check
        $error("sap_core_param: ADDR_W must lie in 1..DATA_W-4");
    end

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_ir;
    logic              r_c;
    logic              r_z;
    logic              r_step_q;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_halted;

    logic [OPC_W-1:0]  w_opc;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rdata;
    logic [ADDR_W-1:0] w_raddr;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_step_rise;

    assign w_opc       = r_ir[DATA_W-1 -: OPC_W];
    assign w_operand   = r_ir[ADDR_W-1:0];
    assign w_imm       = {{OPC_W{1'b0}}, r_ir[DATA_W-OPC_W-1:0]};
    assign w_step_rise = step & ~r_step_q;

    // FETCH reads the instruction at PC; EXEC reads the memory operand.
    assign w_raddr = (r_state == ST_FETCH) ? r_pc : w_operand;

    // STA (EXEC) and host load (LOAD) are the only writers and never overlap.
    // The write depends on the registered state, so an asynchronous reset
    // during an STA EXEC cycle cancels the write at the next edge.
    assign w_we    = ((r_state == ST_EXEC) && (w_opc == OP_STA)) ||
                     ((r_state == ST_LOAD) && load_we);
    assign w_waddr = (r_state == ST_LOAD) ? load_addr : w_operand;
    assign w_wdata = (r_state == ST_LOAD) ? load_data : r_a;

    assign w_sum  = {1'b0, r_a} + {1'b0, w_rdata};
    assign w_diff = r_a - w_rdata;

    sap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= '0;
            r_a         <= '0;
            r_ir        <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_step_q    <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_step_q    <= step;
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_en) begin
                        r_state <= ST_LOAD;
                    end else if (run || w_step_rise) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_ir    <= w_rdata;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    case (w_opc)
                        OP_LDA: begin
                            r_a <= w_rdata;
                            r_z <= (w_rdata == '0);
                        end
                        OP_ADD: begin
                            {r_c, r_a} <= w_sum;
                            r_z        <= (w_sum[DATA_W-1:0] == '0);
                        end
                        OP_SUB: begin
                            r_a <= w_diff;
                            r_c <= (r_a >= w_rdata);
                            r_z <= (w_diff == '0);
                        end
                        OP_LDI: begin
                            r_a <= w_imm;
                            r_z <= (w_imm == '0);
                        end
                        OP_JMP: r_pc <= w_operand;
                        OP_JC:  if (r_c) r_pc <= w_operand;
                        OP_JZ:  if (r_z) r_pc <= w_operand;
                        OP_OUT: begin
                            r_out_data  <= r_a;
                            r_out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                    if (w_opc == OP_HLT) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (load_en) begin
                        r_state <= ST_LOAD;
                    end else if (run) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (load_en) begin
                        r_state  <= ST_LOAD;
                        r_halted <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Leaving load mode restarts the program from a clean slate.
                    if (!load_en) begin
                        r_pc    <= '0;
                        r_a     <= '0;
                        r_c     <= 1'b0;
                        r_z     <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign halted    = r_halted;
    assign pc_dbg    = r_pc;
    assign state_dbg = r_state;

endmodule

// File: tb/tb_sap_core_param.sv
module tb_sap_core_param;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              step;
    logic              load_en;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              halted;
    logic [ADDR_W-1:0] pc_dbg;
    logic [2:0]        state_dbg;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] prog[16];

    sap_core_param #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .step      (step),
        .load_en   (load_en),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .pc_dbg    (pc_dbg),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: every OUT pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL out_unexpected: got 0x%0h, none expected", out_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_fail++;
                    $display("FAIL out_data: got 0x%0h expected 0x%0h", out_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write prog[0..hi] through the load port, then return to IDLE.
    task automatic load_prog(input int hi);
        @(posedge clk); #1;
        run     = 1'b0;
        load_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (state_dbg == 3'd4) break;
        end
        check("enter_load", state_dbg, 3'd4);
        for (int i = 0; i <= hi; i++) begin
            load_addr = ADDR_W'(i);
            load_data = prog[i];
            load_we   = 1'b1;
            @(posedge clk); #1;
        end
        load_we = 1'b0;
        load_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run_to_halt(input string name, input int budget);
        run = 1'b1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
        end
        check({name, "_halted"}, halted, 1'b1);
        run = 1'b0;
        @(negedge clk);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    task automatic fill(input logic [DATA_W-1:0] v);
        for (int i = 0; i < 16; i++) prog[i] = v;
    endtask

    initial begin
        int first_ov;
        int first_h;
        int n_ov;
        int prev_pc;
        logic wrapped;

        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        load_en = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc_dbg, 4'd0);
        check("rst_state", state_dbg, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_rst", state_dbg, 3'd0);

        // 0x1C + 0x0E = 0x2A with exact timing
        fill(8'hF0);
        prog[0] = 8'h0E; prog[1] = 8'h1F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'h1C; prog[15] = 8'h0E;
        load_prog(15);
        exp_q.push_back(8'h2A);
        first_ov = -1; first_h = -1; n_ov = 0;
        run = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                n_ov++;
                if (first_ov < 0) first_ov = k;
            end
            if (halted === 1'b1 && first_h < 0) first_h = k;
        end
        check("ov_cycle", first_ov, 7);
        check("ov_pulses", n_ov, 1);
        check("halt_cycle", first_h, 9);
        check("a_sb_empty", exp_q.size(), 0);

        // HALT ignores run and step
        step = 1'b1;
        repeat (3) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_state", state_dbg, 3'd3);
        check("halt_pc", pc_dbg, 4'd4);
        run = 1'b0;

        // load_en in HALT -> LOAD, rerun after release
        @(negedge clk);
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        check("halt_to_load", state_dbg, 3'd4);
        check("load_halted_clr", halted, 1'b0);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        check("load_exit_state", state_dbg, 3'd0);
        check("load_exit_pc", pc_dbg, 4'd0);
        exp_q.push_back(8'h2A);
        run_to_halt("rerun", 100);

        // ADD 0xF0+0x20 -> 0x10, C=1, Z=0
        fill(8'hF0);
        prog[0] = 8'h0E; prog[1] = 8'h1F; prog[2] = 8'hE0; prog[3] = 8'h78;
        prog[4] = 8'h66; prog[5] = 8'hF0; prog[6] = 8'h47; prog[7] = 8'hE0;
        prog[14] = 8'hF0; prog[15] = 8'h20;
        load_prog(15);
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h07);
        run_to_halt("add", 100);

        // SUB 5-5 -> 0 (C=1,Z=1); SUB 3-5 -> 0xFE (C=0,Z=0)
        fill(8'hF0);
        prog[0] = 8'h0E; prog[1] = 8'h2E; prog[2] = 8'hE0; prog[3] = 8'h75;
        prog[4] = 8'hF0; prog[5] = 8'h67; prog[6] = 8'hF0; prog[7] = 8'h0F;
        prog[8] = 8'h2E; prog[9] = 8'hE0; prog[10] = 8'h64; prog[11] = 8'h74;
        prog[12] = 8'hE0; prog[13] = 8'hF0; prog[14] = 8'h05; prog[15] = 8'h03;
        load_prog(15);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'hFE);
        run_to_halt("sub", 150);

        // Countdown loop
        fill(8'hF0);
        prog[0] = 8'h43; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'h75;
        prog[4] = 8'h51; prog[5] = 8'hF0; prog[15] = 8'h01;
        load_prog(15);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h00);
        run_to_halt("count", 200);
        check("count_pc", pc_dbg, 4'd6);

        // Step mode, held step, STA/LDA round trip
        fill(8'hF0);
        prog[0] = 8'h45; prog[1] = 8'h3D; prog[2] = 8'h40; prog[3] = 8'h0D;
        prog[4] = 8'hE0; prog[5] = 8'hF0; prog[13] = 8'h00;
        load_prog(13);
        for (int s = 1; s <= 3; s++) begin
            @(negedge clk);
            step = 1'b1;
            repeat (6) @(negedge clk);
            check($sformatf("step%0d_pc", s), pc_dbg, ADDR_W'(s));
            check($sformatf("step%0d_state", s), state_dbg, 3'd0);
            step = 1'b0;
            @(negedge clk);
        end
        exp_q.push_back(8'h05);
        run_to_halt("sta", 100);

        // PC wraps 15 -> 0 over a program of NOPs
        fill(8'h80);
        load_prog(15);
        run = 1'b1;
        prev_pc = 0;
        wrapped = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (prev_pc == 15 && pc_dbg == 4'd0) wrapped = 1'b1;
            prev_pc = int'(pc_dbg);
        end
        check("pc_wrap", wrapped, 1'b1);
        check("wrap_not_halted", halted, 1'b0);

        // Reset during EXEC of STA: no write, outputs cleared
        fill(8'hF0);
        prog[0] = 8'h49; prog[1] = 8'h3C; prog[2] = 8'hF0; prog[12] = 8'h77;
        load_prog(12);
        @(negedge clk);
        step = 1'b1;
        repeat (6) @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        check("pre_sta_pc", pc_dbg, 4'd1);
        step = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (state_dbg == 3'd2) break;
        end
        check("sta_in_exec", state_dbg, 3'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_halted", halted, 1'b0);
        check("mid_rst_pc", pc_dbg, 4'd0);
        check("mid_rst_state", state_dbg, 3'd0);
        step = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prog[0] = 8'h0C; prog[1] = 8'hE0; prog[2] = 8'hF0;
        load_prog(2);
        exp_q.push_back(8'h77);
        run_to_halt("no_sta_write", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
